// File: rtl/dec_gpr_wb_arb.sv
// dec_gpr_wb_arb: GPR writeback arbiter (ALU vs buffered FPU) with an FPU-destination busy scoreboard.
// Latency: ALU accept -> wen0 next cycle; FPU push -> wen0 two cycles later (one when bypassing an empty FIFO).
// Backpressure: fpu_ready drops while the FIFO is full; alu_ready drops only while a full FIFO drains its head.
// Optional feature macro: WB_BYPASS_EN (empty-FIFO FPU bypass). Default build has it disabled.

// Generic circular-buffer FIFO used to hold FPU results.
// Caller never pushes when full nor pops when empty; head_dat_o is valid whenever cnt_o != 0.
// DEPTH must be a power of two so the pointers wrap naturally.
module dec_gpr_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_vld_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  // Storage: written at the tail; contents are only observed through cnt_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_vld_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_vld_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_vld_i, pop_vld_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;

endmodule

module dec_gpr_wb_arb #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_waddr,
  input  logic [XLEN-1:0]               alu_wd,
  input  logic                          fpu_valid,
  output logic                          fpu_ready,
  input  logic [4:0]                    fpu_waddr,
  input  logic [XLEN-1:0]               fpu_wd,
  input  logic                          sb_set,
  input  logic [4:0]                    sb_set_addr,
  input  logic [4:0]                    chk_addr0,
  input  logic [4:0]                    chk_addr1,
  output logic                          chk_busy0,
  output logic                          chk_busy1,
  output logic                          wen0,
  output logic [4:0]                    waddr0,
  output logic [XLEN-1:0]               wd0,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 5 + XLEN;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // FIFO interface
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_head_dat;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_wd;

  // Selection
  logic            sel_fifo;
  logic            sel_alu;
  logic            sel_byp;
  logic            sel_vld;
  logic            sel_fpu;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_wd;

  // Registered write port
  logic            wen_q;
  logic            wen_d;
  logic [4:0]      waddr_q;
  logic [4:0]      waddr_d;
  logic [XLEN-1:0] wd_q;
  logic [XLEN-1:0] wd_d;

  // Busy scoreboard; bit 0 stands for x0 and is held at zero so it never reports a hazard.
  logic [31:0]     sb_q;
  logic [31:0]     sb_d;

  dec_gpr_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fpu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (fifo_push),
    .push_dat_i ({fpu_waddr, fpu_wd}),
    .pop_vld_i  (fifo_pop),
    .head_dat_o (fifo_head_dat),
    .cnt_o      (fifo_cnt)
  );

  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_empty = (fifo_cnt == '0);
  assign head_addr  = fifo_head_dat[EW-1:XLEN];
  assign head_wd    = fifo_head_dat[XLEN-1:0];

  assign fpu_ready  = ~fifo_full;
  assign alu_ready  = ~fifo_full;

  // Source selection: a full FIFO pre-empts the ALU so FPU results cannot stall forever,
  // otherwise the ALU wins and the FIFO drains in ALU-idle cycles.
  always_comb begin
    sel_fifo = fifo_full | (~alu_valid & ~fifo_empty);
    sel_alu  = alu_valid & ~fifo_full;
`ifdef WB_BYPASS_EN
    sel_byp  = fifo_empty & ~alu_valid & fpu_valid;
`else
    sel_byp  = 1'b0;
`endif
    sel_vld  = sel_fifo | sel_alu | sel_byp;
    sel_fpu  = sel_fifo | sel_byp;
    sel_addr = '0;
    sel_wd   = '0;
    if (sel_fifo) begin
      sel_addr = head_addr;
      sel_wd   = head_wd;
    end else if (sel_alu) begin
      sel_addr = alu_waddr;
      sel_wd   = alu_wd;
    end else if (sel_byp) begin
      sel_addr = fpu_waddr;
      sel_wd   = fpu_wd;
    end
    // A bypassed result is consumed directly and never enters the FIFO.
    fifo_push = fpu_valid & ~fifo_full & ~sel_byp;
    fifo_pop  = sel_fifo;
  end

  // Next write-port value: x0 targets are consumed but never written; address/data hold when idle.
  always_comb begin
    wen_d   = sel_vld & (sel_addr != 5'd0);
    waddr_d = waddr_q;
    wd_d    = wd_q;
    if (wen_d) begin
      waddr_d = sel_addr;
      wd_d    = sel_wd;
    end
  end

  // Registered GPR write port; reset drops any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wd_q    <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wd_q    <= wd_d;
    end
  end

  // Scoreboard update: clear on the FPU write being registered, then apply issue set so set wins.
  always_comb begin
    sb_d = sb_q;
    if (sel_fpu && (sel_addr != 5'd0)) begin
      sb_d[sel_addr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != 5'd0)) begin
      sb_d[sb_set_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard state; reset forgets all outstanding FPU destinations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign chk_busy0 = sb_q[chk_addr0];
  assign chk_busy1 = sb_q[chk_addr1];

  assign wen0   = wen_q;
  assign waddr0 = waddr_q;
  assign wd0    = wd_q;

endmodule

// File: tb/tb_dec_gpr_wb_arb.sv
`timescale 1ns/1ps
// tb_dec_gpr_wb_arb: scoreboard bench; per-source expected writes queued at handshake, checked at wen0.
module tb_dec_gpr_wb_arb;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_valid, alu_ready, fpu_valid, fpu_ready;
  logic [4:0]      alu_waddr, fpu_waddr, sb_set_addr, chk_addr0, chk_addr1, waddr0;
  logic [XLEN-1:0] alu_wd, fpu_wd, wd0;
  logic            sb_set, chk_busy0, chk_busy1, wen0;
  logic [2:0]      fifo_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] alu_q[$];
  logic [36:0] fpu_q[$];

  dec_gpr_wb_arb #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wd(alu_wd),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_waddr(fpu_waddr), .fpu_wd(fpu_wd),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Writeback monitor: FPU data carries 0xF in the top nibble, everything else is ALU data.
  always @(posedge clk) begin
    logic [36:0] got;
    logic [36:0] exp;
    #1;
    if (!rst && wen0 === 1'b1) begin
      got = {waddr0, wd0};
      n_chk++;
      if (wd0[31:28] == 4'hF) begin
        if (fpu_q.size() == 0) begin
          n_fail++; $display("FAIL wb_fpu_unexpected: got x%0d=%h, none expected", waddr0, wd0);
        end else begin
          exp = fpu_q.pop_front();
          if (got !== exp) begin
            n_fail++; $display("FAIL wb_fpu_order: got x%0d=%h want x%0d=%h", waddr0, wd0, exp[36:32], exp[31:0]);
          end
        end
      end else begin
        if (alu_q.size() == 0) begin
          n_fail++; $display("FAIL wb_alu_unexpected: got x%0d=%h, none expected", waddr0, wd0);
        end else begin
          exp = alu_q.pop_front();
          if (got !== exp) begin
            n_fail++; $display("FAIL wb_alu_order: got x%0d=%h want x%0d=%h", waddr0, wd0, exp[36:32], exp[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_waddr = 0; alu_wd = 0;
    fpu_valid = 0; fpu_waddr = 0; fpu_wd = 0;
    sb_set = 0; sb_set_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); chk_addr0 = 5'd7; chk_addr1 = 5'd31;
    #12;
    n_chk++; if (wen0 !== 1'b0) begin n_fail++; $display("FAIL reset_wen0: got %b want 0", wen0); end
    n_chk++; if (waddr0 !== 5'd0) begin n_fail++; $display("FAIL reset_waddr0: got %0d want 0", waddr0); end
    n_chk++; if (wd0 !== 32'd0) begin n_fail++; $display("FAIL reset_wd0: got %h want 0", wd0); end
    n_chk++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    n_chk++; if ({chk_busy0, chk_busy1} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", {chk_busy0, chk_busy1}); end
    @(negedge clk); rst = 0; #1;
    n_chk++; if ({alu_ready, fpu_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", {alu_ready, fpu_ready}); end
  endtask

  task automatic test_alu();
    step();
    alu_valid = 1; alu_waddr = 5'd5; alu_wd = 32'hDEADBEEF;
    n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
    alu_q.push_back({5'd5, 32'hDEADBEEF});
    step(); idle();
    n_chk++; if ({wen0, waddr0, wd0} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL alu_write: got wen=%b x%0d=%h want wen=1 x5=deadbeef", wen0, waddr0, wd0); end
    step();
    n_chk++; if (wen0 !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle: got wen=%b want 0", wen0); end
  endtask

  task automatic test_fpu_order();
    logic exp_wen;
    step();
    fpu_valid = 1; fpu_waddr = 5'd3; fpu_wd = 32'hF000_0011;
    fpu_q.push_back({5'd3, 32'hF000_0011});
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        fpu_waddr = 5'd4; fpu_wd = 32'hF000_0022;
        fpu_q.push_back({5'd4, 32'hF000_0022});
        n_chk++; if (fifo_cnt !== ((LAT == 2) ? 3'd1 : 3'd0)) begin
          n_fail++; $display("FAIL fpu_cnt: got %0d want %0d", fifo_cnt, (LAT == 2) ? 1 : 0); end
      end else begin
        fpu_valid = 0;
      end
      exp_wen = (k == LAT) || (k == LAT + 1);
      n_chk++; if (wen0 !== exp_wen) begin n_fail++; $display("FAIL fpu_wen k=%0d: got %b want %b", k, wen0, exp_wen); end
      if (exp_wen) begin
        n_chk++; if (waddr0 !== ((k == LAT) ? 5'd3 : 5'd4)) begin
          n_fail++; $display("FAIL fpu_waddr k=%0d: got %0d want %0d", k, waddr0, (k == LAT) ? 3 : 4); end
      end
    end
    idle();
  endtask

  task automatic test_contention();
    int aidx = 0;
    int fidx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      alu_valid = (cyc < 8); alu_waddr = 5'(10 + aidx); alu_wd = 32'hA000_0000 | aidx;
      fpu_valid = (fidx < 5); fpu_waddr = 5'(20 + fidx); fpu_wd = 32'hF000_0000 | fidx;
      if (cyc == 4) begin
        n_chk++; if (fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL cont_full_cnt: got %0d want 4", fifo_cnt); end
        n_chk++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL cont_fpu_ready: got %b want 0", fpu_ready); end
        n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL cont_alu_stall: got %b want 0", alu_ready); end
      end
      if (cyc == 5) begin
        n_chk++; if ({wen0, waddr0, wd0} !== {1'b1, 5'd20, 32'hF000_0000}) begin
          n_fail++; $display("FAIL cont_head: got wen=%b x%0d=%h want wen=1 x20=f0000000", wen0, waddr0, wd0); end
        n_chk++; if ({fifo_cnt, alu_ready} !== {3'd3, 1'b1}) begin
          n_fail++; $display("FAIL cont_resume: got cnt=%0d rdy=%b want cnt=3 rdy=1", fifo_cnt, alu_ready); end
      end
      if (alu_valid && alu_ready) begin alu_q.push_back({alu_waddr, alu_wd}); aidx++; end
      if (fpu_valid && fpu_ready) begin fpu_q.push_back({fpu_waddr, fpu_wd}); fidx++; end
    end
    idle(); step();
    n_chk++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL cont_drained: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_scoreboard();
    chk_addr0 = 5'd7; chk_addr1 = 5'd8;
    step(); sb_set = 1; sb_set_addr = 5'd7;
    n_chk++; if (chk_busy0 !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet: got %b want 0", chk_busy0); end
    step(); sb_set = 0;
    n_chk++; if ({chk_busy0, chk_busy1} !== 2'b10) begin n_fail++; $display("FAIL sb_set: got %b want 10", {chk_busy0, chk_busy1}); end
    // clear by FPU writeback
    step(); fpu_valid = 1; fpu_waddr = 5'd7; fpu_wd = 32'hF000_0077; fpu_q.push_back({5'd7, 32'hF000_0077});
    for (int k = 1; k <= 3; k++) begin
      step(); fpu_valid = 0;
      n_chk++; if (chk_busy0 !== (k < LAT)) begin n_fail++; $display("FAIL sb_clear k=%0d: got %b want %b", k, chk_busy0, (k < LAT)); end
      if (k == LAT) begin
        n_chk++; if ({wen0, waddr0} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL sb_clear_wr: got wen=%b x%0d want wen=1 x7", wen0, waddr0); end
      end
    end
    // set wins over a same-cycle clear
    chk_addr1 = 5'd7;
    step(); sb_set = 1; sb_set_addr = 5'd7;
    step(); sb_set = 0;
    n_chk++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_port1: got %b want 1", chk_busy1); end
    step(); fpu_valid = 1; fpu_waddr = 5'd7; fpu_wd = 32'hF000_0078; fpu_q.push_back({5'd7, 32'hF000_0078});
    sb_set = (LAT == 1);
    for (int k = 1; k <= 3; k++) begin
      step(); fpu_valid = 0; sb_set = (k == LAT - 1);
      n_chk++; if (chk_busy0 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins k=%0d: got %b want 1", k, chk_busy0); end
    end
    sb_set = 0;
    step(); fpu_valid = 1; fpu_wd = 32'hF000_0079; fpu_q.push_back({5'd7, 32'hF000_0079});
    step(); fpu_valid = 0; step(); step();
    n_chk++; if (chk_busy0 !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear: got %b want 0", chk_busy0); end
    idle();
  endtask

  task automatic test_x0();
    chk_addr0 = 5'd0; chk_addr1 = 5'd0;
    step();
    alu_valid = 1; alu_waddr = 5'd0; alu_wd = 32'hA000_0000;
    fpu_valid = 1; fpu_waddr = 5'd0; fpu_wd = 32'hF000_0000;
    sb_set = 1; sb_set_addr = 5'd0;
    n_chk++; if ({alu_ready, fpu_ready} !== 2'b11) begin n_fail++; $display("FAIL x0_ready: got %b want 11", {alu_ready, fpu_ready}); end
    for (int k = 1; k <= 4; k++) begin
      step(); idle();
      n_chk++; if (wen0 !== 1'b0) begin n_fail++; $display("FAIL x0_wen k=%0d: got %b want 0", k, wen0); end
      n_chk++; if ({chk_busy0, chk_busy1} !== 2'b00) begin n_fail++; $display("FAIL x0_busy k=%0d: got %b want 00", k, {chk_busy0, chk_busy1}); end
      if (k == 1) begin
        n_chk++; if (fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL x0_pushed: got %0d want 1", fifo_cnt); end
      end
      if (k == 2) begin
        n_chk++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL x0_consumed: got %0d want 0", fifo_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid();
    chk_addr0 = 5'd9; chk_addr1 = 5'd10;
    step(); sb_set = 1; sb_set_addr = 5'd9;
    step(); sb_set_addr = 5'd10;
    step(); sb_set = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      alu_valid = 1; alu_waddr = 5'(11 + c); alu_wd = 32'hA000_0100 | c;
      fpu_valid = 1; fpu_waddr = 5'(21 + c); fpu_wd = 32'hF000_0100 | c;
      alu_q.push_back({alu_waddr, alu_wd});
      fpu_q.push_back({fpu_waddr, fpu_wd});
    end
    step(); idle();
    n_chk++; if (fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d want 3", fifo_cnt); end
    n_chk++; if ({chk_busy0, chk_busy1} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 11", {chk_busy0, chk_busy1}); end
    #2 rst = 1;
    #1;
    fpu_q.delete();
    n_chk++; if ({wen0, fifo_cnt} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rst_now: got wen=%b cnt=%0d want 0/0", wen0, fifo_cnt); end
    n_chk++; if ({chk_busy0, chk_busy1} !== 2'b00) begin n_fail++; $display("FAIL rst_busy: got %b want 00", {chk_busy0, chk_busy1}); end
    @(posedge clk); @(posedge clk); #1;
    n_chk++; if (wen0 !== 1'b0) begin n_fail++; $display("FAIL rst_hold_wen: got %b want 0", wen0); end
    @(negedge clk); rst = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++; if ({wen0, fifo_cnt} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rst_stale k=%0d: got wen=%b cnt=%0d want 0/0", k, wen0, fifo_cnt); end
    end
  endtask

  task automatic test_drain();
    step(); step();
    n_chk++; if (alu_q.size() !== 0) begin n_fail++; $display("FAIL lost_alu: got %0d pending want 0", alu_q.size()); end
    n_chk++; if (fpu_q.size() !== 0) begin n_fail++; $display("FAIL lost_fpu: got %0d pending want 0", fpu_q.size()); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fpu_order();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
